input_wait_ctrl: RTL and testbench

Consumes the one-cycle press pulse from the button debouncer and implements the processor's INPUT instruction handshake.
- While the CPU requests input, the block stalls the core and blinks a wait LED.
- On the next press it captures the synchronised switch bank and acknowledges the CPU.
- An optional timeout releases the CPU without a press.

---
 rtl/input_wait_ctrl_pkg.sv | 20 ++
 rtl/input_wait_ctrl_bus_sync.sv | 28 ++
 rtl/input_wait_ctrl.sv | 146 ++++++++++++++
 tb/tb_input_wait_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_wait_ctrl_pkg.sv
// Shared definitions for the INPUT-instruction wait controller and the CPU I/O decoder.
package input_wait_ctrl_pkg;

   // Width of the switch bank / INPUT data word, shared with the CPU I/O decoder
   localparam int DATA_W_DEF = 16;

   // Handshake FSM encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Bits needed to count 0 .. n-1 (at least one bit so n = 1 still yields a register)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/input_wait_ctrl_bus_sync.sv
// Two-flop synchroniser for a bus of independent, slowly changing asynchronous bits.
// Each bit is synchronised separately; the bus is not guaranteed coherent while it changes.
module bus_sync #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two back-to-back stages: first may go metastable, second resolves it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/input_wait_ctrl.sv
// INPUT instruction handshake: stalls the CPU while it waits for a button press,
// blinks a wait LED, captures the synchronised switch bank on the press and
// acknowledges the CPU for one cycle. An optional timeout releases the CPU without data.
module input_wait_ctrl
   import input_wait_ctrl_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int BLINK_DIV   = 25000000,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_req,
   input  logic              btn_pulse,
   input  logic [DATA_W-1:0] switches,
   output logic [DATA_W-1:0] in_data,
   output logic              in_ack,
   output logic              timed_out,
   output logic              cpu_stall,
   output logic              wait_led
);

   // Blink counter runs 0 .. BLINK_DIV-1
   localparam int                 BLINK_W    = cnt_width(BLINK_DIV);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

   // Timeout counter gets one spare bit so it can saturate past the terminal count
   localparam int              TO_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0] TO_MAX  = '1;
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   localparam logic            TO_EN   = (TIMEOUT_CYC != 0);

   logic [DATA_W-1:0]  sw_sync;

   state_t             state_q,     state_d;
   logic [DATA_W-1:0]  in_data_q,   in_data_d;
   logic               timed_out_q, timed_out_d;
   logic               wait_led_q,  wait_led_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;

   // Switches are asynchronous to clock; bring them in through two flops
   bus_sync #(
      .W (DATA_W)
   ) u_sw_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (switches),
      .q       (sw_sync)
   );

   // State, captured data and counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         in_data_q   <= '0;
         timed_out_q <= 1'b0;
         wait_led_q  <= 1'b0;
         blink_cnt_q <= '0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         in_data_q   <= in_data_d;
         timed_out_q <= timed_out_d;
         wait_led_q  <= wait_led_d;
         blink_cnt_q <= blink_cnt_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   // Next-state: request arms WAIT, press (or timeout) completes it, HOLD waits for the CPU to drop the request
   always_comb begin
      state_d     = state_q;
      in_data_d   = in_data_q;
      timed_out_d = timed_out_q;
      wait_led_d  = 1'b0;          // LED is dark in every state except WAIT
      blink_cnt_d = blink_cnt_q;
      to_cnt_d    = to_cnt_q;

      case (state_q)
         IDLE: begin
            // A press seen here is stale and is simply dropped
            if (in_req) begin
               state_d     = WAIT;
               blink_cnt_d = '0;
               to_cnt_d    = '0;
               wait_led_d  = 1'b1;
            end
         end

         WAIT: begin
            wait_led_d = wait_led_q;
            if (!in_req) begin
               // CPU flushed the INPUT instruction: abandon without acknowledging
               state_d    = IDLE;
               wait_led_d = 1'b0;
            end else if (btn_pulse) begin
               // A press beats a timeout landing on the same cycle
               in_data_d   = sw_sync;
               timed_out_d = 1'b0;
               state_d     = ACK;
               wait_led_d  = 1'b0;
            end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
               timed_out_d = 1'b1;
               state_d     = ACK;
               wait_led_d  = 1'b0;
            end else begin
               if (TO_EN && (to_cnt_q != TO_MAX)) begin
                  to_cnt_d = to_cnt_q + TO_ONE;
               end
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  wait_led_d  = ~wait_led_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BLINK_ONE;
               end
            end
         end

         ACK: begin
            state_d = HOLD;
         end

         HOLD: begin
            // Request still high here belongs to the instruction just served; wait for it to drop
            if (!in_req) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_data   = in_data_q;
   assign in_ack    = (state_q == ACK);
   assign timed_out = timed_out_q;
   assign wait_led  = wait_led_q;
   // Stall drops in ACK so the CPU retires INPUT in the same cycle it sees in_ack
   assign cpu_stall = in_req & ((state_q == IDLE) | (state_q == WAIT));

endmodule

// File: tb/tb_input_wait_ctrl.sv
// Bench for input_wait_ctrl: one instance without timeout, one with an 8-cycle timeout,
// both blinking every 4 cycles. Expected acknowledgements are queued when stimulus is
// driven and matched against the DUT when in_ack appears.
module tb_input_wait_ctrl;
   import input_wait_ctrl_pkg::*;

   localparam int DW = DATA_W_DEF;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0 = 1'b0, btn0 = 1'b0;
   logic          req1 = 1'b0, btn1 = 1'b0;
   logic [DW-1:0] sw = '0;

   logic [DW-1:0] in_data0, in_data1;
   logic          in_ack0, in_ack1;
   logic          timed_out0, timed_out1;
   logic          cpu_stall0, cpu_stall1;
   logic          wait_led0, wait_led1;

   int cyc   = 0;
   int n_chk = 0;
   int n_err = 0;
   int base;

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
      logic          to;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   input_wait_ctrl #(
      .DATA_W      (DW),
      .BLINK_DIV   (4),
      .TIMEOUT_CYC (0)
   ) dut0 (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_req    (req0),
      .btn_pulse (btn0),
      .switches  (sw),
      .in_data   (in_data0),
      .in_ack    (in_ack0),
      .timed_out (timed_out0),
      .cpu_stall (cpu_stall0),
      .wait_led  (wait_led0)
   );

   input_wait_ctrl #(
      .DATA_W      (DW),
      .BLINK_DIV   (4),
      .TIMEOUT_CYC (8)
   ) dut1 (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_req    (req1),
      .btn_pulse (btn1),
      .switches  (sw),
      .in_data   (in_data1),
      .in_ack    (in_ack1),
      .timed_out (timed_out1),
      .cpu_stall (cpu_stall1),
      .wait_led  (wait_led1)
   );

   always #5 clock = ~clock;

   // Cycle index: cycle n is the period following the n-th rising edge
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input int c, input logic [DW-1:0] d, input logic t);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      e.to   = t;
      return e;
   endfunction

   // Advance to 1 time unit after the rising edge that starts cycle n
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Scoreboard for instance 0
   always @(negedge clock) begin
      if (reset_n && in_ack0 === 1'b1) begin
         check("ack0_expected", (q0.size() > 0), 1);
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check("ack0_cycle", cyc, e0.cyc);
            check("ack0_data", in_data0, e0.data);
            check("ack0_timed_out", timed_out0, e0.to);
         end
      end
   end

   // Scoreboard for instance 1
   always @(negedge clock) begin
      if (reset_n && in_ack1 === 1'b1) begin
         check("ack1_expected", (q1.size() > 0), 1);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check("ack1_cycle", cyc, e1.cyc);
            check("ack1_data", in_data1, e1.data);
            check("ack1_timed_out", timed_out1, e1.to);
         end
      end
   end

   initial begin
      // ---- reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_data", in_data0, 0);
      check("rst_in_ack", in_ack0, 0);
      check("rst_timed_out", timed_out1, 0);
      check("rst_wait_led", wait_led0, 0);
      check("rst_stall", cpu_stall0, 0);
      reset_n = 1'b1;

      // ---- presses without a request are ignored
      base = cyc;
      goto(base + 2); btn0 = 1'b1;
      goto(base + 3); btn0 = 1'b0;
      goto(base + 5); btn0 = 1'b1;
      goto(base + 6); btn0 = 1'b0;
      goto(base + 8); #1;
      check("idle_in_data", in_data0, 0);
      check("idle_stall", cpu_stall0, 0);
      check("idle_led", wait_led0, 0);

      // ---- basic capture, held request, press in HOLD ignored
      base = cyc;
      sw = 16'h00A5;
      goto(base + 10); req0 = 1'b1;
      for (int c = 10; c <= 20; c++) begin
         goto(base + c);
         if (c == 20) begin
            btn0 = 1'b1;
            q0.push_back(mk(base + 21, 16'h00A5, 1'b0));
         end
         #1;
         check("cap_stall_wait", cpu_stall0, 1);
      end
      goto(base + 21); btn0 = 1'b0; #1;
      check("cap_stall_ack", cpu_stall0, 0);
      goto(base + 25); btn0 = 1'b1;
      goto(base + 26); btn0 = 1'b0; #1;
      check("hold_stall", cpu_stall0, 0);
      goto(base + 30); req0 = 1'b0;
      goto(base + 32); #1;
      check("cap_in_data_held", in_data0, 16'h00A5);
      check("cap_timed_out", timed_out0, 0);

      // ---- stale press before request; capture shows 2-cycle switch latency
      base = cyc;
      sw = 16'h1234;
      goto(base + 5); btn0 = 1'b1;
      goto(base + 6); btn0 = 1'b0; req0 = 1'b1;
      goto(base + 12); #1;
      check("stale_still_stall", cpu_stall0, 1);
      check("stale_in_data", in_data0, 16'h00A5);
      goto(base + 15); sw = 16'h5678;
      goto(base + 16); btn0 = 1'b1;
      q0.push_back(mk(base + 17, 16'h1234, 1'b0));
      goto(base + 17); btn0 = 1'b0;
      goto(base + 18); req0 = 1'b0;
      goto(base + 20); #1;
      check("sync_in_data", in_data0, 16'h1234);

      // ---- flush while waiting
      base = cyc;
      goto(base + 1); req0 = 1'b1;
      goto(base + 5); #1;
      check("flush_led_before", wait_led0, 1);
      req0 = 1'b0; #1;
      check("flush_stall", cpu_stall0, 0);
      goto(base + 6); #1;
      check("flush_led_after", wait_led0, 0);
      check("flush_in_data", in_data0, 16'h1234);
      goto(base + 9); #1;
      check("flush_no_ack", in_ack0, 0);

      // ---- blink: led lit on WAIT entry, toggles every 4 cycles
      base = cyc;
      goto(base + 1); req0 = 1'b1;
      for (int c = 2; c <= 21; c++) begin
         goto(base + c);
         if (c == 21) begin
            btn0 = 1'b1;
            q0.push_back(mk(base + 22, 16'h5678, 1'b0));
         end
         #1;
         check("blink_led", wait_led0, (((c - 2) / 4) % 2 == 0) ? 1 : 0);
      end
      goto(base + 22); btn0 = 1'b0; #1;
      check("blink_led_ack", wait_led0, 0);
      goto(base + 23); req0 = 1'b0;
      goto(base + 25); #1;
      check("blink_led_idle", wait_led0, 0);

      // ---- timeout with no press: ack 8 cycles after WAIT entry
      base = cyc;
      goto(base + 1); req1 = 1'b1;
      q1.push_back(mk(base + 10, 16'h0000, 1'b1));
      goto(base + 9); #1;
      check("to_stall_wait", cpu_stall1, 1);
      goto(base + 10); #1;
      check("to_stall_ack", cpu_stall1, 0);
      goto(base + 11); #1;
      check("to_sticky", timed_out1, 1);
      req1 = 1'b0;
      goto(base + 13);

      // ---- press on the 7th WAIT cycle
      base = cyc;
      sw = 16'h9ABC;
      goto(base + 1); req1 = 1'b1;
      goto(base + 8); btn1 = 1'b1;
      q1.push_back(mk(base + 9, 16'h9ABC, 1'b0));
      goto(base + 9); btn1 = 1'b0;
      goto(base + 10); req1 = 1'b0;
      goto(base + 12);

      // ---- press in the same cycle the timeout would fire: press wins
      base = cyc;
      sw = 16'h0F0F;
      goto(base + 1); req1 = 1'b1;
      goto(base + 9); btn1 = 1'b1;
      q1.push_back(mk(base + 10, 16'h0F0F, 1'b0));
      goto(base + 10); btn1 = 1'b0;
      goto(base + 11); #1;
      check("race_timed_out", timed_out1, 0);
      req1 = 1'b0;
      goto(base + 13);

      // ---- asynchronous reset mid-run (inst 0 in WAIT, inst 1 in HOLD after timeout)
      base = cyc;
      goto(base + 1); req0 = 1'b1; req1 = 1'b1;
      q1.push_back(mk(base + 10, 16'h0F0F, 1'b1));
      goto(base + 12); #1;
      check("mid_led_pre", wait_led0, 1);
      check("mid_to_pre", timed_out1, 1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_in_data0", in_data0, 0);
      check("mid_led0", wait_led0, 0);
      check("mid_ack0", in_ack0, 0);
      check("mid_timed_out1", timed_out1, 0);
      check("mid_in_data1", in_data1, 0);
      check("mid_stall_req_held", cpu_stall0, 1);
      req0 = 1'b0; req1 = 1'b0; #1;
      check("mid_stall0", cpu_stall0, 0);
      check("mid_stall1", cpu_stall1, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      base = cyc;
      goto(base + 3); #1;
      check("post_rst_led", wait_led0, 0);
      check("post_rst_ack1", in_ack1, 0);

      // ---- every expected acknowledgement must have been seen
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
